aline_scan_sequencer: RTL and testbench

- Frame-level controller for `transmit_fsm`.
- Steps through `num_alines` A-lines per frame. For each A-line it fetches one 8-channel delay profile from an external synchronous table, loads it into `transmit_fsm`, fires the transmit and waits for completion.
- Holds a programmable pulse-repetition interval (PRI), then pulses `next_aline`.
- Sits between the host/config registers and `transmit_fsm`.

---
 rtl/scan_seq_pkg.sv | 29 ++
 rtl/aline_scan_sequencer_if.sv | 39 +++
 rtl/pri_timer.sv | 37 +++
 rtl/aline_scan_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_aline_scan_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/scan_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scan_seq_pkg
// Description : Shared types and default widths for the A-line scan sequencer.
//               Holds the sequencer state encoding, default delay / index /
//               PRI widths, and the number of cycles start_transmit is held.
// Revision    : 1.0 - initial release
// ============================================================================
package scan_seq_pkg;

  localparam int DELAY_W            = 16;
  localparam int IDX_W              = 8;
  localparam int PRI_W              = 16;
  localparam int START_PULSE_CYCLES = 2;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    LATCH    = 4'd2,
    LOAD     = 4'd3,
    FIRE     = 4'd4,
    WAIT_TX  = 4'd5,
    WAIT_PRI = 4'd6,
    ADVANCE  = 4'd7,
    DONE     = 4'd8
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aline_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : aline_scan_sequencer_if
// Description : Delay-table and transmit_fsm side bus of the scan sequencer.
//   tbl_rd_en / tbl_addr      : table read strobe and address (A-line index)
//   tbl_rd_data               : table row, valid one cycle after tbl_rd_en
//   delay_bus                 : per-channel delays to transmit_fsm (ch0 LSBs)
//   input_delay_data          : one-cycle delay load strobe
//   start_transmit            : fire strobe
//   transmit_in_progress      : status from transmit_fsm
//   transmit_complete         : completion from transmit_fsm
//   master modport = sequencer, slave modport = table + transmit_fsm side.
// Revision    : 1.0 - initial release
// ============================================================================
interface aline_scan_sequencer_if #(
  parameter int NUM_CH  = 8,
  parameter int DELAY_W = 16,
  parameter int IDX_W   = 8
);
  logic                      tbl_rd_en;
  logic [IDX_W-1:0]          tbl_addr;
  logic [NUM_CH*DELAY_W-1:0] tbl_rd_data;
  logic [NUM_CH*DELAY_W-1:0] delay_bus;
  logic                      input_delay_data;
  logic                      start_transmit;
  logic                      transmit_in_progress;
  logic                      transmit_complete;

  modport master (
    output tbl_rd_en, tbl_addr, delay_bus, input_delay_data, start_transmit,
    input  tbl_rd_data, transmit_in_progress, transmit_complete
  );

  modport slave (
    input  tbl_rd_en, tbl_addr, delay_bus, input_delay_data, start_transmit,
    output tbl_rd_data, transmit_in_progress, transmit_complete
  );
endinterface
`default_nettype wire

// File: rtl/pri_timer.sv
`default_nettype none
// ============================================================================
// Module      : pri_timer
// Description : Loadable, saturating up-counter with a threshold compare.
//   clk, rst   : clock, synchronous active-high reset
//   i_load     : clear the count to zero on the next edge
//   i_limit    : threshold
//   o_reached  : count >= i_limit - 1 (true for any count when i_limit = 0)
// Revision    : 1.0 - initial release
// ============================================================================
module pri_timer #(
  parameter int W = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_load,
  input  wire logic [W-1:0] i_limit,
  output logic              o_reached
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= '0;
    end else if (r_count != {W{1'b1}}) begin
      r_count <= r_count + W'(1);
    end
  end

  // Compare count+1 against the limit in W+1 bits so a zero limit cannot underflow.
  assign o_reached = ({1'b0, r_count} + {{W{1'b0}}, 1'b1}) >= {1'b0, i_limit};

endmodule
`default_nettype wire

// File: rtl/aline_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : aline_scan_sequencer
// Description : Frame-level controller for transmit_fsm. For each A-line it
//               reads a delay profile from the table, loads it, fires the
//               transmit, waits for completion and the PRI, then advances.
//   clk, rst        : clock, synchronous active-high reset
//   i_frame_start   : pulse, starts a frame from IDLE
//   i_frame_abort   : level, ends the frame after the current A-line
//   i_num_alines    : A-lines per frame (0 behaves as 1), latched at start
//   i_pri_cycles    : clocks from start_transmit to next_aline, latched
//   bus             : table / transmit_fsm bus (master modport)
//   o_next_aline    : one-cycle A-line advance
//   o_aline_idx     : current A-line
//   o_frame_busy    : high outside IDLE
//   o_frame_done    : one-cycle frame end pulse
//   o_tx_error      : sticky transmit watchdog error
// Build option: ALINE_TX_WATCHDOG_EN enables the TX_TIMEOUT watchdog; without
//               it WAIT_TX waits indefinitely and o_tx_error is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module aline_scan_sequencer #(
  parameter int NUM_CH     = 8,
  parameter int DELAY_W    = scan_seq_pkg::DELAY_W,
  parameter int IDX_W      = scan_seq_pkg::IDX_W,
  parameter int PRI_W      = scan_seq_pkg::PRI_W,
  parameter int TX_TIMEOUT = 4096
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_frame_start,
  input  wire logic               i_frame_abort,
  input  wire logic [IDX_W-1:0]   i_num_alines,
  input  wire logic [PRI_W-1:0]   i_pri_cycles,
  aline_scan_sequencer_if.master  bus,
  output logic                    o_next_aline,
  output logic [IDX_W-1:0]        o_aline_idx,
  output logic                    o_frame_busy,
  output logic                    o_frame_done,
  output logic                    o_tx_error
);

  import scan_seq_pkg::*;

  localparam logic [1:0] c_fire_last = 2'(START_PULSE_CYCLES - 1);

  state_t                    r_state;
  state_t                    w_next;
  logic [IDX_W-1:0]          r_aline_idx;
  logic [IDX_W-1:0]          r_last_idx;
  logic [PRI_W-1:0]          r_pri_limit;
  logic [NUM_CH*DELAY_W-1:0] r_delay_bus;
  logic [1:0]                r_fire_cnt;
  logic                      w_start_frame;
  logic                      w_timer_load;
  logic                      w_pri_done;
  logic                      w_wd_timeout;
  logic                      w_tbl_rd_en;
  logic                      w_load;
  logic                      w_start;
  logic                      w_next_aline;
  logic                      w_frame_done;
  logic                      w_unused;

  assign w_start_frame = (r_state == IDLE) && i_frame_start;

  // Loading in LOAD makes both timers read 0 during the first FIRE cycle, so
  // their count equals clocks elapsed since start_transmit rose.
  assign w_timer_load = (r_state == LOAD);

  pri_timer #(.W(PRI_W)) u_pri_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timer_load),
    .i_limit   (r_pri_limit),
    .o_reached (w_pri_done)
  );

`ifdef ALINE_TX_WATCHDOG_EN
  localparam int c_wd_w = $clog2(TX_TIMEOUT + 1);

  logic r_tx_error;

  pri_timer #(.W(c_wd_w)) u_wd_timer (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_timer_load),
    .i_limit   (c_wd_w'(TX_TIMEOUT)),
    .o_reached (w_wd_timeout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_error <= 1'b0;
    end else if (w_start_frame) begin
      r_tx_error <= 1'b0;
    end else if (r_state == WAIT_TX && !bus.transmit_complete && w_wd_timeout) begin
      r_tx_error <= 1'b1;
    end
  end

  assign o_tx_error = r_tx_error;
`else
  assign w_wd_timeout = 1'b0;
  assign o_tx_error   = 1'b0;
`endif

  // Status input from transmit_fsm is not needed for sequencing.
  assign w_unused = bus.transmit_in_progress ^ (TX_TIMEOUT == 0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_tbl_rd_en  = 1'b0;
    w_load       = 1'b0;
    w_start      = 1'b0;
    w_next_aline = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE:     if (i_frame_start) w_next = FETCH;
      FETCH: begin
        w_tbl_rd_en = 1'b1;
        w_next      = LATCH;
      end
      LATCH:    w_next = LOAD;
      LOAD: begin
        w_load = 1'b1;
        w_next = FIRE;
      end
      FIRE: begin
        w_start = 1'b1;
        if (r_fire_cnt == c_fire_last) w_next = WAIT_TX;
      end
      // Completion wins over a same-cycle timeout; if the PRI is already
      // satisfied the advance follows completion directly.
      WAIT_TX: begin
        if (bus.transmit_complete) begin
          w_next = w_pri_done ? ADVANCE : WAIT_PRI;
        end else if (w_wd_timeout) begin
          w_next = DONE;
        end
      end
      WAIT_PRI: if (w_pri_done) w_next = ADVANCE;
      ADVANCE: begin
        w_next_aline = 1'b1;
        if (r_aline_idx == r_last_idx || i_frame_abort) w_next = DONE;
        else                                             w_next = FETCH;
      end
      DONE: begin
        w_frame_done = 1'b1;
        w_next       = IDLE;
      end
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_aline_idx <= '0;
      r_last_idx  <= '0;
      r_pri_limit <= '0;
      r_delay_bus <= '0;
      r_fire_cnt  <= '0;
    end else begin
      if (w_start_frame) begin
        r_aline_idx <= '0;
        r_last_idx  <= (i_num_alines == '0) ? '0 : i_num_alines - IDX_W'(1);
        r_pri_limit <= i_pri_cycles;
      end else if (r_state == ADVANCE && w_next == FETCH) begin
        r_aline_idx <= r_aline_idx + IDX_W'(1);
      end
      if (r_state == LATCH) r_delay_bus <= bus.tbl_rd_data;
      r_fire_cnt <= (r_state == FIRE) ? r_fire_cnt + 2'd1 : 2'd0;
    end
  end

  assign bus.tbl_rd_en        = w_tbl_rd_en;
  assign bus.tbl_addr         = r_aline_idx;
  assign bus.delay_bus        = r_delay_bus;
  assign bus.input_delay_data = w_load;
  assign bus.start_transmit   = w_start;
  assign o_next_aline         = w_next_aline;
  assign o_aline_idx          = r_aline_idx;
  assign o_frame_busy         = (r_state != IDLE);
  assign o_frame_done         = w_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_aline_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_aline_scan_sequencer
// Description : Self-checking bench for aline_scan_sequencer. A table model and
//               a transmit_fsm responder surround the DUT; a monitor records
//               strobe times, and each frame is compared with a timeline
//               computed from the frame rules. Watchdog frame runs only when
//               ALINE_TX_WATCHDOG_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aline_scan_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        frame_abort = 1'b0;
  logic [7:0]  num_alines = 8'd0;
  logic [15:0] pri = 16'd0;
  logic        next_aline, frame_busy, frame_done, tx_error;
  logic [7:0]  aline_idx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int tx_lat = 0;
  int tgt    = -1;
  bit st_prev = 1'b0;

  logic [127:0] tbl [256];
  int           q_rd [$];
  int           q_addr [$];
  int           q_idd [$];
  logic [127:0] q_dly [$];
  int           q_st [$];
  int           q_na [$];
  int           q_fd [$];
  int           q_fd_idx [$];
  int           q_fd_err [$];

  aline_scan_sequencer_if #(.NUM_CH(8), .DELAY_W(16), .IDX_W(8)) bus ();

  aline_scan_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .i_frame_start(frame_start),
    .i_frame_abort(frame_abort),
    .i_num_alines (num_alines),
    .i_pri_cycles (pri),
    .bus          (bus),
    .o_next_aline (next_aline),
    .o_aline_idx  (aline_idx),
    .o_frame_busy (frame_busy),
    .o_frame_done (frame_done),
    .o_tx_error   (tx_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous delay table: data valid one cycle after the read strobe.
  always @(posedge clk) if (bus.tbl_rd_en) bus.tbl_rd_data <= tbl[bus.tbl_addr];

  // transmit_fsm stand-in: complete tx_lat cycles after start rises (0 = never).
  always @(negedge clk) begin
    if (!frame_busy) tgt = -1;
    else if (bus.start_transmit && !st_prev && tx_lat > 0) tgt = cyc + tx_lat;
    st_prev = bus.start_transmit;
    bus.transmit_complete    = (tgt >= 0 && cyc == tgt);
    bus.transmit_in_progress = (tgt >= 0 && cyc < tgt);
  end

  always @(negedge clk) begin
    if (bus.tbl_rd_en) begin
      q_rd.push_back(cyc);
      q_addr.push_back(int'(bus.tbl_addr));
    end
    if (bus.input_delay_data) begin
      q_idd.push_back(cyc);
      q_dly.push_back(bus.delay_bus);
    end
    if (bus.start_transmit) q_st.push_back(cyc);
    if (next_aline) q_na.push_back(cyc);
    if (frame_done) begin
      q_fd.push_back(cyc);
      q_fd_idx.push_back(int'(aline_idx));
      q_fd_err.push_back(int'(tx_error));
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int k);
    return (k < q.size()) ? q[k] : -1;
  endfunction

  task automatic check_quiet(input string tag);
    chk({tag, "_busy"}, 128'(frame_busy), 128'(0));
    chk({tag, "_strobes"}, 128'({bus.tbl_rd_en, bus.input_delay_data, bus.start_transmit,
                                 next_aline, frame_done, tx_error}), 128'(0));
    chk({tag, "_aline_idx"}, 128'(aline_idx), 128'(0));
    chk({tag, "_tbl_addr"}, 128'(bus.tbl_addr), 128'(0));
    chk({tag, "_delay_bus"}, bus.delay_bus, 128'(0));
  endtask

  task automatic fill_table(input bit ramp);
    for (int k = 0; k < 256; k++)
      for (int c = 0; c < 8; c++)
        tbl[k][c*16 +: 16] = ramp ? 16'(2 * k) : 16'($urandom);
  endtask

  // One frame: drive it, then compare every recorded strobe with the timeline
  // expected from the frame rules (lat = 0 means the transmit never completes).
  task automatic run_frame(input int n, input int p, input int lat,
                           input int abort_line, input int poke);
    int n0, lines, t, s, na, done_t, budget;
    int b_rd, b_idd, b_st, b_na, b_fd;
    bit wd;
    wd = (lat == 0);
    tx_lat = lat;
    @(negedge clk);
    b_rd = q_rd.size(); b_idd = q_idd.size(); b_st = q_st.size();
    b_na = q_na.size(); b_fd = q_fd.size();
    num_alines = 8'(n); pri = 16'(p); frame_start = 1'b1; n0 = cyc;
    @(negedge clk);
    frame_start = 1'b0; num_alines = 8'($urandom); pri = 16'($urandom);
    chk("tx_error_clear", 128'(tx_error), 128'(0));
    budget = 0;
    while (q_fd.size() == b_fd && budget < 20000) begin
      @(negedge clk);
      budget++;
      frame_start = (cyc == n0 + poke);
      if (abort_line >= 0 && q_rd.size() - b_rd > abort_line) frame_abort = 1'b1;
    end
    frame_start = 1'b0; frame_abort = 1'b0;
    chk("frame_ends", 128'(budget < 20000), 128'(1));
    repeat (2) @(negedge clk);
    chk("busy_after_done", 128'(frame_busy), 128'(0));
    chk("tx_error_after", 128'(tx_error), 128'(wd));

    lines = (n == 0) ? 1 : n;
    if (abort_line >= 0 && abort_line + 1 < lines) lines = abort_line + 1;
    if (wd) lines = 1;
    chk("rd_count", 128'(q_rd.size() - b_rd), 128'(lines));
    chk("start_cycles", 128'(q_st.size() - b_st), 128'(2 * lines));
    chk("next_aline_count", 128'(q_na.size() - b_na), 128'(wd ? 0 : lines));
    chk("done_count", 128'(q_fd.size() - b_fd), 128'(1));
    t = n0 + 1;
    done_t = -1;
    for (int k = 0; k < lines; k++) begin
      s = t + 3;
      chk("rd_time", 128'(qget(q_rd, b_rd + k)), 128'(t));
      chk("rd_addr", 128'(qget(q_addr, b_rd + k)), 128'(k));
      chk("load_time", 128'(qget(q_idd, b_idd + k)), 128'(t + 2));
      chk("delay_bus", (b_idd + k < q_dly.size()) ? q_dly[b_idd + k] : 128'bx, tbl[k]);
      chk("start_1st", 128'(qget(q_st, b_st + 2 * k)), 128'(s));
      chk("start_2nd", 128'(qget(q_st, b_st + 2 * k + 1)), 128'(s + 1));
      if (wd) begin
        done_t = s + 4096;
      end else begin
        na = (p > lat + 1) ? s + p : s + lat + 1;
        chk("next_aline_time", 128'(qget(q_na, b_na + k)), 128'(na));
        t = na + 1;
        done_t = na + 1;
      end
    end
    chk("done_time", 128'(qget(q_fd, b_fd)), 128'(done_t));
    chk("done_idx", 128'(qget(q_fd_idx, b_fd)), 128'(lines - 1));
    chk("done_tx_error", 128'(qget(q_fd_err, b_fd)), 128'(wd));
  endtask

  initial begin
    int n0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Basic frame: ramp table, 60-cycle PRI, 20-cycle transmit.
    fill_table(1'b1);
    run_frame(4, 60, 20, -1, -1);
    // Short PRI: advance one cycle after completion.
    fill_table(1'b0);
    run_frame(2, 5, 30, -1, -1);
    // Abort during A-line 2 of 8.
    run_frame(8, 40, 15, 2, -1);
    // Zero A-lines behaves as one; frame_start while busy is ignored.
    run_frame(0, 10, 4, -1, 5);

    // Reset while waiting out the PRI.
    tx_lat = 10;
    @(negedge clk);
    num_alines = 8'd3; pri = 16'd60; frame_start = 1'b1; n0 = cyc;
    @(negedge clk);
    frame_start = 1'b0;
    while (cyc < n0 + 24) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("midreset");
    run_frame(2, 12, 6, -1, -1);

    // Randomized frames.
    for (int i = 0; i < 8; i++) begin
      fill_table(1'b0);
      run_frame($urandom_range(1, 5), $urandom_range(0, 80), $urandom_range(2, 40),
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : -1,
                ($urandom_range(0, 1) == 0) ? $urandom_range(2, 7) : -1);
    end

`ifdef ALINE_TX_WATCHDOG_EN
    // Transmit never completes: watchdog ends the frame, next frame clears it.
    run_frame(3, 30, 0, -1, -1);
    run_frame(1, 10, 5, -1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
